// File: rtl/mii_pkg.sv
// Shared constants, state encoding and small helpers for the 64-bit MII frame checker.
package mii_pkg;

  localparam logic [7:0] IDLE_CODE  = 8'h07;
  localparam logic [7:0] START_CODE = 8'hFB;
  localparam logic [7:0] EOF_CODE   = 8'hFD;
  localparam logic [7:0] ERROR_CODE = 8'hFE;
  localparam logic [7:0] PREAMBLE   = 8'h55;
  localparam logic [7:0] SFD        = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_DATA = 3'b010,
    ST_DROP = 3'b100
  } state_t;

  localparam int ERR_PREAMBLE = 0;
  localparam int ERR_SFD      = 1;
  localparam int ERR_CTRL     = 2;
  localparam int ERR_RUNT     = 3;
  localparam int ERR_OVERSIZE = 4;
  localparam int ERR_IDLE     = 5;
  localparam int ERR_TRUNC    = 6;

  // Lanes 0..k-1 valid; k=0 gives an empty mask.
  function automatic logic [7:0] laneMask(input logic [2:0] k);
    return (8'd1 << k) - 8'd1;
  endfunction

  // Length accumulation that sticks at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] satAdd(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/mii_lane_scan.sv
// Combinational scan of one MII word: locates the lowest control lane and
// qualifies it as a terminate followed only by idle characters.
module mii_lane_scan
  import mii_pkg::*;
(
  input  logic [63:0] i_mii_rx_d,
  input  logic [7:0]  i_mii_rx_c,
  output logic [2:0]  o_lane,
  output logic        o_found,
  output logic        o_is_fd,
  output logic        o_trail_idle_ok
);

  always_comb begin
    o_found = |i_mii_rx_c;
    o_lane  = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (i_mii_rx_c[j]) o_lane = 3'(j);
    end
    o_is_fd = o_found && (i_mii_rx_d[{o_lane, 3'b000} +: 8] == EOF_CODE);
    o_trail_idle_ok = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if ((3'(j) > o_lane) && !(i_mii_rx_c[j] && (i_mii_rx_d[8*j +: 8] == IDLE_CODE)))
        o_trail_idle_ok = 1'b0;
    end
  end

endmodule

// File: rtl/mii_checker.sv
// 64-bit MII receive checker: strips start/preamble, forwards frame bytes
// lane-aligned, and reports length, error cause and good/bad frame counts.
module mii_checker
  import mii_pkg::*;
#(
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int MIN_FRAME_SIZE   = 64
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [63:0] i_mii_rx_d,
  input  logic [7:0]  i_mii_rx_c,
  output logic [63:0] o_data,
  output logic        o_data_valid,
  output logic [7:0]  o_keep,
  output logic        o_sof,
  output logic        o_eof,
  output logic [15:0] o_frame_len,
  output logic        o_frame_err,
  output logic [7:0]  o_err_code,
  output logic [31:0] o_good_cnt,
  output logic [31:0] o_bad_cnt
);

  localparam int MAX_FRAME = PAYLOAD_MAX_SIZE + 18;

  state_t      r_state, w_next_state;
  logic [15:0] r_len, w_len_next, w_frame_len;
  logic        r_sof_pend, w_sof_pend_next;
  logic        w_out, w_sof, w_eof, w_len_check;
  logic [7:0]  w_keep, w_err;
  logic [63:0] w_data;

  logic [2:0]  w_lane;
  logic        w_found, w_is_fd, w_trail_ok;
  logic        w_pre_ok, w_sfd_ok, w_start_lane, w_is_start;

  mii_lane_scan u_scan (
    .i_mii_rx_d      (i_mii_rx_d),
    .i_mii_rx_c      (i_mii_rx_c),
    .o_lane          (w_lane),
    .o_found         (w_found),
    .o_is_fd         (w_is_fd),
    .o_trail_idle_ok (w_trail_ok)
  );

  assign w_pre_ok     = (i_mii_rx_c[6:1] == 6'd0) && (i_mii_rx_d[55:8] == {6{PREAMBLE}});
  assign w_sfd_ok     = !i_mii_rx_c[7] && (i_mii_rx_d[63:56] == SFD);
  assign w_start_lane = i_mii_rx_c[0] && (i_mii_rx_d[7:0] == START_CODE);
  assign w_is_start   = w_start_lane && w_pre_ok && w_sfd_ok;

  always_comb begin
    w_next_state    = r_state;
    w_len_next      = r_len;
    w_sof_pend_next = r_sof_pend;
    w_frame_len     = r_len;
    w_out           = 1'b0;
    w_sof           = 1'b0;
    w_eof           = 1'b0;
    w_keep          = 8'h00;
    w_err           = 8'h00;
    w_len_check     = 1'b0;
    w_data          = 64'd0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_is_start) begin
          w_next_state    = ST_DATA;
          w_len_next      = 16'd0;
          w_sof_pend_next = 1'b1;
        end else if (w_start_lane) begin
          w_out        = 1'b1;
          w_eof        = 1'b1;
          w_frame_len  = 16'd0;
          w_next_state = ST_DROP;
          if (w_pre_ok) w_err[ERR_SFD] = 1'b1;
          else          w_err[ERR_PREAMBLE] = 1'b1;
        end
      end
      ST_DATA: begin
        // A fresh start closes the current frame empty-handed and reopens.
        if (w_is_start) begin
          w_out            = 1'b1;
          w_eof            = 1'b1;
          w_sof            = r_sof_pend;
          w_err[ERR_TRUNC] = 1'b1;
          w_len_check      = 1'b1;
          w_len_next       = 16'd0;
          w_sof_pend_next  = 1'b1;
        end else if (!w_found) begin
          w_out           = 1'b1;
          w_sof           = r_sof_pend;
          w_keep          = 8'hFF;
          w_sof_pend_next = 1'b0;
          w_len_next      = satAdd(r_len, 4'd8);
        end else begin
          w_out       = 1'b1;
          w_eof       = 1'b1;
          w_sof       = r_sof_pend;
          w_keep      = laneMask(w_lane);
          w_frame_len = satAdd(r_len, {1'b0, w_lane});
          w_len_check = 1'b1;
          if (w_is_fd) begin
            w_err[ERR_IDLE] = !w_trail_ok;
            w_next_state    = ST_IDLE;
          end else begin
            w_err[ERR_CTRL] = 1'b1;
            w_next_state    = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (w_is_start) begin
          w_next_state    = ST_DATA;
          w_len_next      = 16'd0;
          w_sof_pend_next = 1'b1;
        end else if (w_is_fd) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase

    if (w_len_check) begin
      if (int'(w_frame_len) < MIN_FRAME_SIZE) w_err[ERR_RUNT] = 1'b1;
      if (int'(w_frame_len) > MAX_FRAME)      w_err[ERR_OVERSIZE] = 1'b1;
    end

    for (int j = 0; j < 8; j++) begin
      w_data[8*j +: 8] = w_keep[j] ? i_mii_rx_d[8*j +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= 16'd0;
      r_sof_pend <= 1'b0;
    end else if (i_valid) begin
      r_state    <= w_next_state;
      r_len      <= w_len_next;
      r_sof_pend <= w_sof_pend_next;
    end
  end

  // Idle words only drop the valid strobe; everything else holds.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= 64'd0;
      o_data_valid <= 1'b0;
      o_keep       <= 8'h00;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_frame_len  <= 16'd0;
      o_frame_err  <= 1'b0;
      o_err_code   <= 8'h00;
      o_good_cnt   <= 32'd0;
      o_bad_cnt    <= 32'd0;
    end else if (i_valid) begin
      o_data_valid <= w_out;
      o_data       <= w_data;
      o_keep       <= w_keep;
      o_sof        <= w_sof;
      o_eof        <= w_eof;
      if (w_eof) begin
        o_frame_len <= w_frame_len;
        o_err_code  <= w_err;
        o_frame_err <= |w_err;
        if (|w_err) o_bad_cnt  <= o_bad_cnt + 32'd1;
        else        o_good_cnt <= o_good_cnt + 32'd1;
      end
    end else begin
      o_data_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mii_checker.md
MII_CHECKER -- requirements
Module: mii_checker

Interface
REQ-001 SHALL have parameter PAYLOAD_MAX_SIZE, default 1500, maximum client payload in bytes; maximum frame = PAYLOAD_MAX_SIZE+18 bytes (DA..FCS).
REQ-002 SHALL have parameter MIN_FRAME_SIZE, default 64, minimum frame in bytes (DA..FCS).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  the current word on i_mii_rx_d/i_mii_rx_c is valid.
REQ-006 i_mii_rx_d  input  64  receive data; lane k = bits [8k+7:8k], lane 0 first on wire.
REQ-007 i_mii_rx_c  input  8  per-lane control flag; 1 = lane carries a control character.
REQ-008 o_data  output  64  frame bytes (DA..FCS), lane-aligned to lane 0.
REQ-009 o_data_valid  output  1  o_data/o_keep qualifier.
REQ-010 o_keep  output  8  valid-lane mask, contiguous from lane 0.
REQ-011 o_sof / o_eof  output  1 each  first / last frame word markers, qualified by o_data_valid.
REQ-012 o_frame_len  output  16  byte count of the frame, valid with o_eof.
REQ-013 o_frame_err  output  1  frame error, valid with o_eof.
REQ-014 o_err_code  output  8  one-hot error cause: [0] bad preamble, [1] bad SFD, [2] unexpected control, [3] runt, [4] oversize, [5] bad idle after terminate, [6] truncated by new start; [7] reserved, always 0.
REQ-015 o_good_cnt / o_bad_cnt  output  32 each  wrap-around counts of good and errored frames.

Function
REQ-016 Words with i_valid=0 SHALL be ignored; state, counters and outputs other than o_data_valid SHALL hold.
REQ-017 States: IDLE, DATA, DROP; one-hot encoding.
REQ-018 IDLE: a start word has c=8'h01, lane0=8'hFB, lanes1-6=8'h55, lane7=8'hD5; it SHALL move to DATA with no output.
REQ-019 IDLE: c[0]=1 and lane0=FB but preamble/SFD wrong -> DROP; o_eof pulse, o_frame_err=1, err bit 0 or 1 set, o_frame_len=0.
REQ-020 IDLE: any other word produces no output; non-07 control characters are ignored.
REQ-021 DATA, c=8'h00: output the word with o_keep=8'hFF; o_sof=1 on the first word after start; length += 8.
REQ-022 DATA, terminate detection: k = lowest lane with c[k]=1. If lane k = 8'hFD, then lanes 0..k-1 are data and output with o_keep = (1<<k)-1, o_eof=1, length += k. If k=0, output a word with o_keep=0 and o_eof=1. Next state is IDLE.
REQ-023 After FD in lane k, lanes k+1..7 SHALL be control 8'h07; otherwise set err bit 5.
REQ-024 DATA, control lane ≠ FD (for example 8'hFE): set err bit 2, o_eof with data lanes below it, go to DROP.
REQ-025 DATA, start word received: close the current frame with o_eof, o_keep=0, err bit 6; treat the word as a new start (REQ-018).
REQ-026 At o_eof: length < MIN_FRAME_SIZE sets bit 3; length > max sets bit 4. Oversize frames keep being forwarded until the terminate.
REQ-027 Length counter SHALL saturate at 16'hFFFF.
REQ-028 DROP: ignore words until a word containing FD or a start word; FD -> IDLE; start -> REQ-018.
REQ-029 o_frame_err = |o_err_code. At o_eof, o_good_cnt increments if no error, else o_bad_cnt increments; exactly one per frame.
REQ-030 Latency: outputs are registered; the input word at edge N appears at edge N+1.
REQ-031 o_data_valid is a one-cycle pulse per processed word; o_sof and o_eof may both be 1 in the same word.

Reset
REQ-032 Asserting i_rst_n=0 SHALL immediately force state=IDLE and all outputs and counters to 0; a frame in progress is discarded without o_eof.
REQ-033 After deassertion, the first accepted frame SHALL begin with a full start word.

Structure
REQ-034 Package mii_pkg SHALL hold IDLE_CODE 07, START_CODE FB, EOF_CODE FD, ERROR_CODE FE, PREAMBLE 55, SFD D5, the state type, and the err-bit indices.
REQ-035 Sub-module mii_lane_scan: combinational; from i_mii_rx_c/i_mii_rx_d gives first-control-lane index, found flag, is-FD, and trailing-idle-ok.

Verification
REQ-036 Start word, 8 data words, then {7×07,FD} with c=FF -> 8 words of keep FF, then a keep-00 eof; len=64, err=0, good_cnt=1.
REQ-037 Start word, 8 data words, then a terminate word with FD in lane 3 and 07 in lanes 4-7 -> last keep=8'h07, len=67, err=0.
REQ-038 Start word, 3 data words, terminate in lane 0 -> len=24, err=8'h08, bad_cnt=1.
REQ-039 Start word with lane7=8'h55 -> eof with err=8'h02; following data words ignored until FD.
REQ-040 Mid-frame FE control in lane 2 -> eof with keep=8'h03, err=8'h04; DROP until FD, then the next good frame is counted as good.
REQ-041 i_rst_n=0 mid-frame -> no eof, counts 0; the next full frame is received correctly.
